// File: rtl/fir_32nd_pkg.sv
// Shared constants, sample type and the Q15 coefficient table of the
// 33-tap linear-phase ECG low-pass filter (0.1*fs cutoff, Hamming, DC gain 1.0).
package fir_32nd_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 33;
  localparam int FRAC   = 15;
  localparam int ACC_W  = 40;
  localparam int HALF   = TAPS / 2;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  // Symmetric table, h[k] == h[32-k]; the entries sum to exactly 32768.
  localparam coef_t COEF [0:TAPS-1] = '{
    -16'sd31,   16'sd0,     16'sd50,    16'sd120,   16'sd178,   16'sd159,
     16'sd0,   -16'sd307,  -16'sd669,  -16'sd893,  -16'sd732,   16'sd0,
     16'sd1326, 16'sd3050,  16'sd4786,  16'sd6077,  16'sd6540,  16'sd6077,
     16'sd4786, 16'sd3050,  16'sd1326,  16'sd0,    -16'sd732,  -16'sd893,
    -16'sd669, -16'sd307,   16'sd0,     16'sd159,   16'sd178,   16'sd120,
     16'sd50,   16'sd0,    -16'sd31
  };

endpackage

// File: rtl/fir_round_sat.sv
// Converts the full-precision accumulator back to a Q15 sample:
// round half up by adding 2^(FRAC-1) before the arithmetic shift, then clamp.
module fir_round_sat
  import fir_32nd_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output sample_t                 result
);

  localparam logic signed [ACC_W-1:0] BIAS    = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  logic signed [ACC_W-1:0] shifted;

  // The accumulator never approaches 2^39, so the bias add cannot overflow.
  assign shifted = (acc + BIAS) >>> FRAC;

  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fir_32nd.sv
// 33-tap symmetric FIR: one sample in and one registered sample out per clock,
// free-running with no handshake. Symmetric taps are pre-added to share multipliers.
module fir_32nd
  import fir_32nd_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  sample_t data_in,
  output sample_t filtered_output
);

  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;

  sample_t                  taps [0:TAPS-1];
  logic signed [PRE_W-1:0]  pre_sum;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc;
  sample_t                  rounded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        taps[k] <= '0;
      end
      filtered_output <= '0;
    end else begin
      taps[0] <= data_in;
      for (int k = 1; k < TAPS; k++) begin
        taps[k] <= taps[k-1];
      end
      filtered_output <= rounded;
    end
  end

  // Exact in every step: 17-bit pre-sum, 33-bit product, 40-bit running sum.
  always_comb begin
    acc     = '0;
    pre_sum = '0;
    product = '0;
    for (int k = 0; k < HALF; k++) begin
      pre_sum = PRE_W'(taps[k]) + PRE_W'(taps[TAPS-1-k]);
      product = PROD_W'(pre_sum) * PROD_W'(COEF[k]);
      acc     = acc + ACC_W'(product);
    end
    pre_sum = PRE_W'(taps[HALF]);
    product = PROD_W'(pre_sum) * PROD_W'(COEF[HALF]);
    acc     = acc + ACC_W'(product);
  end

  fir_round_sat u_round_sat (
    .acc    (acc),
    .result (rounded)
  );

endmodule

// File: tb/tb_fir_32nd.sv
// Bench for fir_32nd: direct-form golden model over the sample history,
// per-cycle scoreboard compare, and literal impulse/DC/saturation/reset checks.
`timescale 1ns/1ps
module tb_fir_32nd;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic [15:0] filtered_output;

  int tests = 0;
  int fails = 0;

  int          hist[$];   // hist[0] is the most recent sample taken by the filter
  logic [15:0] exp_q[$];
  logic [15:0] g;

  int h_lit [0:16] = '{-31, 0, 50, 120, 178, 159, 0, -307, -669, -893, -732,
                       0, 1326, 3050, 4786, 6077, 6540};

  fir_32nd dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .filtered_output (filtered_output)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic int h_at(input int k);
    return h_lit[(k <= 16) ? k : 32 - k];
  endfunction

  function automatic logic [15:0] golden();
    longint acc = 0;
    for (int k = 0; k < 33; k++) begin
      acc += longint'(h_at(k)) * longint'(hist[k]);
    end
    acc = (acc + 16384) >>> 15;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic clear_history();
    hist.delete();
    for (int k = 0; k < 33; k++) hist.push_back(0);
  endtask

  always @(negedge reset) begin
    exp_q.delete();
    clear_history();
  end

  // The output after an edge reflects history up to the previous edge.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.push_back(golden());
      hist.push_front(int'($signed(data_in)));
      if (hist.size() > 33) void'(hist.pop_back());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("stream", filtered_output, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic [15:0] x, output logic [15:0] got);
    data_in = x;
    @(posedge clk);
    #1 got = filtered_output;
  endtask

  logic [15:0] x;

  initial begin
    reset   = 1'b1;
    data_in = '0;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", filtered_output, 16'h0000);
    reset = 1'b1;

    // Positive impulse: outputs are exactly h[0..32], then zero.
    cycle(16'h7FFF, g);
    for (int k = 0; k < 33; k++) begin
      cycle(16'h0000, g);
      check("impulse", g, 16'(h_at(k)));
      if (k == 0)  check("impulse_first", g, 16'hFFE1);
      if (k == 16) check("impulse_center", g, 16'h198C);
      if (k == 32) check("impulse_last", g, 16'hFFE1);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(16'h0000, g);
      check("impulse_flushed", g, 16'h0000);
    end

    // Negative impulse: outputs are exactly -h[k].
    cycle(16'h8000, g);
    for (int k = 0; k < 33; k++) begin
      cycle(16'h0000, g);
      check("neg_impulse", g, 16'(-h_at(k)));
      if (k == 16) check("neg_impulse_center", g, 16'hE674);
    end

    // DC at negative full scale.
    for (int i = 0; i < 40; i++) begin
      cycle(16'h8000, g);
      if (i >= 33) check("dc_neg", g, 16'h8000);
    end

    // Saturation: sign-matched full-scale pattern, then its inverse.
    for (int j = 0; j < 33; j++) cycle((h_at(32 - j) >= 0) ? 16'h7FFF : 16'h8000, g);
    cycle(16'h0000, g);
    check("sat_pos", g, 16'h7FFF);
    for (int j = 0; j < 33; j++) cycle((h_at(32 - j) >= 0) ? 16'h8000 : 16'h7FFF, g);
    cycle(16'h0000, g);
    check("sat_neg", g, 16'h8000);

    // DC at positive full scale, then reset mid-stream.
    for (int i = 0; i < 40; i++) begin
      cycle(16'h7FFF, g);
      if (i >= 33) check("dc_pos", g, 16'h7FFF);
    end
    reset = 1'b0;
    #1 check("reset_async", filtered_output, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      cycle(16'h0000, g);
      check("reset_hold", g, 16'h0000);
    end
    reset = 1'b1;
    for (int i = 0; i < 36; i++) begin
      cycle(16'h0000, g);
      check("after_release", g, 16'h0000);
    end

    // Two-cycle pacing with random samples, extremes weighted in.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 9))
        0:       x = 16'h7FFF;
        1:       x = 16'h8000;
        default: x = 16'($urandom);
      endcase
      cycle(x, g);
      cycle(x, g);
    end
    for (int i = 0; i < 32; i++) cycle(16'h0000, g);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
